// File: rtl/fetch_queue_pkg.sv
// Shared widths, end-of-program marker and queue entry layout for the fetch queue.
package fetch_queue_pkg;
  localparam int          INST_W      = 32;
  localparam int          FETCH_BYTES = 8;
  localparam logic [31:0] END_MARKER  = 32'd0;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [31:0]       pc;
  } fq_entry_t;
endpackage

// File: rtl/fetch_queue_fifo.sv
// fq_fifo: dual-push/dual-pop circular buffer of {inst, pc}; pushes land next cycle,
// head slots are combinational reads; caller guarantees free space (asserted).
module fq_fifo
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         clear_i,
  input  logic                         push0_i,
  input  logic                         push1_i,
  input  logic [INST_W-1:0]            push_inst0_i,
  input  logic [31:0]                  push_pc0_i,
  input  logic [INST_W-1:0]            push_inst1_i,
  input  logic [31:0]                  push_pc1_i,
  input  logic [1:0]                   pop_cnt_i,
  output logic [INST_W-1:0]            head_inst0_o,
  output logic [31:0]                  head_pc0_o,
  output logic [INST_W-1:0]            head_inst1_o,
  output logic [31:0]                  head_pc1_o,
  output logic [$clog2(DEPTH):0]       count_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fq_entry_t          mem_q [DEPTH];
  logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
  logic [PTR_W-1:0]   head1, tail1;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [1:0]         push_n;

  assign push_n = {1'b0, push0_i} + {1'b0, push1_i};
  assign head1  = head_q + PTR_W'(1);
  assign tail1  = tail_q + PTR_W'(1);

  // Pointer arithmetic relies on PTR_W-bit wrap, hence the power-of-two depth.
  always_comb begin
    head_d  = head_q + PTR_W'(pop_cnt_i);
    tail_d  = tail_q + PTR_W'(push_n);
    count_d = count_q + CNT_W'(push_n) - CNT_W'(pop_cnt_i);
    if (clear_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && !clear_i) begin
      if (push0_i) mem_q[tail_q] <= '{inst: push_inst0_i, pc: push_pc0_i};
      if (push1_i) mem_q[tail1]  <= '{inst: push_inst1_i, pc: push_pc1_i};
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && !clear_i) begin
      assert (int'(count_q) + int'(push_n) - int'(pop_cnt_i) <= DEPTH);
      assert (int'(pop_cnt_i) <= int'(count_q));
    end
  end

  assign head_inst0_o = mem_q[head_q].inst;
  assign head_pc0_o   = mem_q[head_q].pc;
  assign head_inst1_o = mem_q[head1].inst;
  assign head_pc1_o   = mem_q[head1].pc;
  assign count_o      = count_q;
endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues 8-byte fetches, buffers pairs, dispatches up to two per cycle;
// 1-cycle fetch latency, issue stalls when free space minus in-flight reservation drops below 2.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter int          DEPTH    = 8
) (
  input  logic               clk,
  input  logic               rst,
  output logic [31:0]        pc,
  input  logic [INST_W-1:0]  inst1,
  input  logic [INST_W-1:0]  inst2,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  output logic               deq_valid0,
  output logic               deq_valid1,
  output logic [INST_W-1:0]  deq_inst0,
  output logic [INST_W-1:0]  deq_inst1,
  output logic [31:0]        deq_pc0,
  output logic [31:0]        deq_pc1,
  input  logic               deq_ready,
  output logic               done
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [31:0]      pc_q, pc_d;
  logic [31:0]      inflight_pc_q, inflight_pc_d;
  logic             inflight_v_q, inflight_v_d;
  logic             halted_q, halted_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] count;
  logic             issue, resp_ok, push0, push1, halt_set;
  logic [1:0]       pop_cnt;

  // An outstanding fetch reserves two slots; same-cycle pops are deliberately not credited.
  always_comb begin
    issue = 1'b0;
    if (!halted_q && !redirect &&
        (DEPTH - int'(count) - (inflight_v_q ? 2 : 0)) >= 2)
      issue = 1'b1;
  end

  // Responses after the halting group are beyond the end of program and are dropped.
  assign resp_ok  = inflight_v_q && !halted_q && !redirect;
  assign push0    = resp_ok && (inst1 != END_MARKER);
  assign push1    = push0 && (inst2 != END_MARKER);
  assign halt_set = resp_ok && ((inst1 == END_MARKER) || (inst2 == END_MARKER));

  always_comb begin
    pop_cnt = 2'd0;
    if (deq_ready && !redirect) begin
      if (count >= CNT_W'(2))      pop_cnt = 2'd2;
      else if (count == CNT_W'(1)) pop_cnt = 2'd1;
    end
  end

  always_comb begin
    pc_d          = pc_q;
    inflight_v_d  = issue;
    inflight_pc_d = inflight_pc_q;
    halted_d      = halted_q | halt_set;
    done_d        = halted_q && (count == '0) && !inflight_v_q;
    if (issue) begin
      pc_d          = pc_q + 32'(FETCH_BYTES);
      inflight_pc_d = pc_q;
    end
    if (redirect) begin
      pc_d         = redirect_pc;
      inflight_v_d = 1'b0;
      halted_d     = 1'b0;
      done_d       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      inflight_pc_q <= RESET_PC;
      inflight_v_q  <= 1'b0;
      halted_q      <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_v_q  <= inflight_v_d;
      halted_q      <= halted_d;
      done_q        <= done_d;
    end
  end

  fq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i        (clk),
    .rst_i        (rst),
    .clear_i      (redirect),
    .push0_i      (push0),
    .push1_i      (push1),
    .push_inst0_i (inst1),
    .push_pc0_i   (inflight_pc_q),
    .push_inst1_i (inst2),
    .push_pc1_i   (inflight_pc_q + 32'd4),
    .pop_cnt_i    (pop_cnt),
    .head_inst0_o (deq_inst0),
    .head_pc0_o   (deq_pc0),
    .head_inst1_o (deq_inst1),
    .head_pc1_o   (deq_pc1),
    .count_o      (count)
  );

  assign pc         = pc_q;
  assign deq_valid0 = (count != '0);
  assign deq_valid1 = (count >= CNT_W'(2));
  assign done       = done_q;
endmodule

// File: tb/tb_fetch_queue.sv
// Directed + random bench: fetch-unit memory model and a program-order dispatch scoreboard.
module tb_fetch_queue;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc;
  logic [31:0] inst1 = '0, inst2 = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        deq_valid0, deq_valid1;
  logic [31:0] deq_inst0, deq_inst1, deq_pc0, deq_pc1;
  logic        deq_ready = 1'b0;
  logic        done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } ent_t;
  ent_t        exp_q[$];
  logic [31:0] mem [0:1023];
  logic [31:0] fa;

  fetch_queue #(.RESET_PC(32'd0), .DEPTH(8)) dut (
    .clk(clk), .rst(rst), .pc(pc), .inst1(inst1), .inst2(inst2),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .deq_valid0(deq_valid0), .deq_valid1(deq_valid1),
    .deq_inst0(deq_inst0), .deq_inst1(deq_inst1),
    .deq_pc0(deq_pc0), .deq_pc1(deq_pc1),
    .deq_ready(deq_ready), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rd(input logic [31:0] a);
    return mem[a[11:2]];
  endfunction

  // Fetch unit: captures pc at the edge, answers one cycle later.
  always @(posedge clk) begin
    fa = pc;
    #1;
    inst1 = rd(fa);
    inst2 = rd(fa + 32'd4);
  end

  // Expected dispatch stream: walk memory in 8-byte groups until the end marker.
  function automatic void build(input logic [31:0] start);
    logic [31:0] a;
    exp_q.delete();
    a = start;
    for (int g = 0; g < 256; g++) begin
      if (rd(a) == 32'd0) break;
      exp_q.push_back('{inst: rd(a), pc: a});
      if (rd(a + 32'd4) == 32'd0) break;
      exp_q.push_back('{inst: rd(a + 32'd4), pc: a + 32'd4});
      a = a + 32'd8;
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic take(input string tag, input logic [31:0] inst, input logic [31:0] ipc);
    ent_t e;
    chk({tag, "_expected"}, 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk({tag, "_inst"}, inst, e.inst);
      chk({tag, "_pc"}, ipc, e.pc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (deq_ready && !redirect && !rst) begin
      chk("valid1_implies_valid0", 32'(!deq_valid1 || deq_valid0), 32'd1);
      if (deq_valid0) take("slot0", deq_inst0, deq_pc0);
      if (deq_valid1) take("slot1", deq_inst1, deq_pc1);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_redirect(input logic [31:0] tgt);
    redirect_pc = tgt;
    redirect    = 1'b1;
    tick();
    redirect = 1'b0;
    build(tgt);
    chk("redir_pc", pc, tgt);
    chk("redir_done", 32'(done), 32'd0);
    chk("redir_empty", 32'(deq_valid0), 32'd0);
  endtask

  task automatic drain(input string tag, input int limit, input bit rnd);
    int n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      if (rnd) deq_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    chk({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    deq_ready = 1'b1;
    while (done !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_done_latency_le4"}, 32'(n <= 4), 32'd1);
  endtask

  initial begin
    logic [31:0] w;
    int n;
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    mem[0] = 32'h0000_1111; mem[1] = 32'h0000_2222;
    mem[2] = 32'h0000_3333; mem[3] = 32'h0000_4444;
    for (int i = 16; i < 22; i++) mem[i] = 32'h4000_0000 + 32'(i);
    mem[64] = 32'h0050_0093;
    for (int i = 128; i < 168; i++) mem[i] = 32'h2000_0000 + 32'(i);
    for (int i = 192; i < 232; i++) mem[i] = 32'h3000_0000 + 32'(i);
    for (int i = 320; i < 325; i++) mem[i] = 32'h5000_0000 + 32'(i);
    for (int i = 384; i < 424; i++) begin w = $urandom; mem[i] = (w == 0) ? 32'd1 : w; end
    for (int i = 512; i < 552; i++) begin w = $urandom; mem[i] = (w == 0) ? 32'd7 : w; end

    // Reset, then a four-word program from address 0.
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    build(32'd0);
    deq_ready = 1'b1;
    chk("reset_pc", pc, 32'd0);
    chk("reset_valid0", 32'(deq_valid0), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    tick();
    chk("pc_seq_8", pc, 32'd8);
    tick();
    chk("pc_seq_16", pc, 32'd16);
    chk("pair0_valid1", 32'(deq_valid1), 32'd1);
    chk("pair0_pc0", deq_pc0, 32'd0);
    chk("pair0_pc1", deq_pc1, 32'd4);
    tick();
    chk("pair1_pc0", deq_pc0, 32'd8);
    chk("pair1_pc1", deq_pc1, 32'd12);
    drain("prog0", 20, 1'b0);
    wait_done("prog0");

    // Single-instruction program: odd end marker halts with one entry.
    deq_ready = 1'b0;
    do_redirect(32'h100);
    for (int i = 0; i < 5; i++) tick();
    chk("single_valid0", 32'(deq_valid0), 32'd1);
    chk("single_valid1", 32'(deq_valid1), 32'd0);
    chk("single_inst", deq_inst0, 32'h0050_0093);
    chk("single_pc", deq_pc0, 32'h100);
    chk("single_not_done", 32'(done), 32'd0);
    deq_ready = 1'b1;
    drain("single", 4, 1'b0);
    wait_done("single");
    do_redirect(32'd0);
    drain("restart", 20, 1'b0);
    wait_done("restart");

    // Back-pressure: queue fills, pc stops after DEPTH/2 groups.
    deq_ready = 1'b0;
    do_redirect(32'h200);
    for (int i = 0; i < 12; i++) tick();
    chk("full_pc", pc, 32'h220);
    chk("full_valid1", 32'(deq_valid1), 32'd1);
    chk("full_head_pc", deq_pc0, 32'h200);
    for (int i = 0; i < 3; i++) tick();
    chk("full_pc_hold", pc, 32'h220);
    deq_ready = 1'b1;
    drain("long", 200, 1'b0);
    wait_done("long");

    // Redirect while a fetch is outstanding.
    do_redirect(32'h300);
    tick();
    tick();
    do_redirect(32'h40);
    n = 0;
    while (!deq_valid0 && n < 10) begin tick(); n++; end
    chk("redir_first_pc", deq_pc0, 32'h40);
    drain("redir40", 40, 1'b0);
    wait_done("redir40");

    // Reset mid-stream with five entries queued.
    deq_ready = 1'b0;
    do_redirect(32'h500);
    for (int i = 0; i < 8; i++) tick();
    chk("five_valid1", 32'(deq_valid1), 32'd1);
    chk("five_head_pc", deq_pc0, 32'h500);
    rst = 1'b1;
    redirect_pc = 32'h700;
    redirect = 1'b1;
    tick();
    rst = 1'b0;
    redirect = 1'b0;
    chk("midrst_pc", pc, 32'd0);
    chk("midrst_valid0", 32'(deq_valid0), 32'd0);
    chk("midrst_valid1", 32'(deq_valid1), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    build(32'd0);
    deq_ready = 1'b1;
    drain("after_rst", 20, 1'b0);
    wait_done("after_rst");

    // Random programs, random back-pressure, redirect amid push/pop traffic.
    do_redirect(32'h600);
    for (int i = 0; i < 12; i++) begin
      deq_ready = 1'($urandom_range(0, 1));
      tick();
    end
    deq_ready = 1'b1;
    do_redirect(32'h800);
    chk("rand_len", 32'(exp_q.size()), 32'd40);
    drain("rand", 500, 1'b1);
    wait_done("rand");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
